// File: rtl/uart_cmd_decoder.sv
// UART hex calculator command parser: turns "<hexA><op><hexB><TERM>"
// into ALU operands, an opcode and a one-cycle start pulse.
module uart_cmd_decoder #(
    parameter int          MAX_DIGITS = 8,
    parameter int          DATA_W     = 32,
    parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        uart_in,
    input  logic              uart_in_valid,
    input  logic              alu_done,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        opcode,
    output logic              alu_start,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_A, S_B, S_ISSUE, S_WAIT, S_FLUSH
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] op_a_n, op_b_n;
    logic [1:0]        opcode_n, err_code_n;
    logic              err_n;

    logic       is_hex, is_sp, is_op, is_term;
    logic [3:0] nib;
    logic [1:0] op_sel;

    always_comb begin
        is_hex  = 1'b0;
        nib     = 4'd0;
        is_op   = 1'b1;
        op_sel  = 2'd0;
        is_sp   = (uart_in == 8'h20);
        is_term = (uart_in == TERM_CHAR) || (uart_in == 8'h3D);
        unique case (1'b1)
            (uart_in >= 8'h30 && uart_in <= 8'h39): begin
                is_hex = 1'b1;
                nib    = uart_in[3:0];
            end
            (uart_in >= 8'h41 && uart_in <= 8'h46),
            (uart_in >= 8'h61 && uart_in <= 8'h66): begin
                is_hex = 1'b1;
                nib    = uart_in[3:0] + 4'd9;
            end
            default: ;
        endcase
        case (uart_in)
            8'h2B:   op_sel = 2'd0;
            8'h2D:   op_sel = 2'd1;
            8'h2A:   op_sel = 2'd2;
            8'h26:   op_sel = 2'd3;
            default: is_op  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_A;
            acc      <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            opcode   <= 2'd0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            op_a     <= op_a_n;
            op_b     <= op_b_n;
            opcode   <= opcode_n;
            err      <= err_n;
            err_code <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        op_a_n     = op_a;
        op_b_n     = op_b;
        opcode_n   = opcode;
        err_n      = 1'b0;
        err_code_n = err_code;
        unique case (state)
            S_A, S_B: begin
                if (uart_in_valid && !is_sp) begin
                    if (is_hex) begin
                        if (cnt == CW'(MAX_DIGITS)) begin
                            err_n      = 1'b1;
                            err_code_n = 2'd2;
                            state_n    = S_FLUSH;
                        end else begin
                            acc_n = {acc[DATA_W-5:0], nib};
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (is_op) begin
                        if (state == S_A && cnt != '0) begin
                            op_a_n   = acc;
                            opcode_n = op_sel;
                            acc_n    = '0;
                            cnt_n    = '0;
                            state_n  = S_B;
                        end else begin
                            err_n      = 1'b1;
                            err_code_n = 2'd3;
                            state_n    = S_FLUSH;
                        end
                    end else if (is_term) begin
                        if (state == S_B && cnt != '0) begin
                            op_b_n  = acc;
                            state_n = S_ISSUE;
                        end else begin
                            // Empty operand: drop partial input, restart at A
                            err_n      = 1'b1;
                            err_code_n = 2'd3;
                            acc_n      = '0;
                            cnt_n      = '0;
                            state_n    = S_A;
                        end
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = 2'd1;
                        state_n    = S_FLUSH;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                if (uart_in_valid) begin
                    err_n      = 1'b1;
                    err_code_n = 2'd0;
                end
                if (state == S_ISSUE) begin
                    state_n = S_WAIT;
                end else if (alu_done) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = S_A;
                end
            end
            S_FLUSH: begin
                if (uart_in_valid && is_term) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = S_A;
                end
            end
            default: state_n = S_A;
        endcase
    end

    always_comb begin
        alu_start = (state == S_ISSUE);
        busy      = (state == S_ISSUE) || (state == S_WAIT);
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: legal commands, error paths,
// busy drops and asynchronous reset, checked with immediate assertions.
module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_in;
    logic        uart_in_valid;
    logic        alu_done;
    logic [31:0] op_a, op_b;
    logic [1:0]  opcode, err_code;
    logic        alu_start, busy, err;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int errs   = 0;
    int base_s, base_e;

    uart_cmd_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .uart_in       (uart_in),
        .uart_in_valid (uart_in_valid),
        .alu_done      (alu_done),
        .op_a          (op_a),
        .op_b          (op_b),
        .opcode        (opcode),
        .alu_start     (alu_start),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (alu_start) starts++;
            if (err) errs++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_in       = b;
        uart_in_valid = 1'b1;
        @(negedge clk);
        uart_in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic done_pulse();
        @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_op_a"}, op_a, 32'h0);
        check({tag, "_op_b"}, op_b, 32'h0);
        check({tag, "_opcode"}, {30'd0, opcode}, 32'd0);
        check({tag, "_start"}, {31'd0, alu_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        uart_in       = 8'h00;
        uart_in_valid = 1'b0;
        alu_done      = 1'b0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 12ab+34cd\r
        base_s = starts;
        base_e = errs;
        send_str("12ab+34cd");
        send_byte(8'h0D);
        check("t1_start", {31'd0, alu_start}, 32'd1);
        check("t1_op_a", op_a, 32'h000012AB);
        check("t1_op_b", op_b, 32'h000034CD);
        check("t1_opcode", {30'd0, opcode}, 32'd0);
        repeat (6) @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_nstart", starts - base_s, 32'd1);
        done_pulse();
        check("t1_busy_clr", {31'd0, busy}, 32'd0);
        check("t1_noerr", errs - base_e, 32'd0);

        // FFFFFFFF*0000000a=
        send_str("FFFFFFFF*0000000a");
        send_byte(8'h3D);
        check("t2_start", {31'd0, alu_start}, 32'd1);
        check("t2_op_a", op_a, 32'hFFFFFFFF);
        check("t2_op_b", op_b, 32'h0000000A);
        check("t2_opcode", {30'd0, opcode}, 32'd2);
        done_pulse();
        check("t2_busy_clr", {31'd0, busy}, 32'd0);

        // digit overflow
        base_s = starts;
        base_e = errs;
        send_str("12345678");
        send_byte("9");
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_code", {30'd0, err_code}, 32'd2);
        repeat (9) @(negedge clk);
        send_str("+1\r");
        check("t3_nstart", starts - base_s, 32'd0);
        check("t3_nerr", errs - base_e, 32'd1);
        check("t3_op_a_kept", op_a, 32'hFFFFFFFF);
        send_str("1-2");
        send_byte(8'h0D);
        check("t3b_start", {31'd0, alu_start}, 32'd1);
        check("t3b_op_a", op_a, 32'h1);
        check("t3b_op_b", op_b, 32'h2);
        check("t3b_opcode", {30'd0, opcode}, 32'd1);
        done_pulse();

        // syntax and illegal-character errors
        base_s = starts;
        base_e = errs;
        send_byte("+");
        check("t4a_err", {31'd0, err}, 32'd1);
        check("t4a_code", {30'd0, err_code}, 32'd3);
        repeat (9) @(negedge clk);
        send_str("5\r");
        send_str("5+");
        send_byte(8'h0D);
        check("t4b_err", {31'd0, err}, 32'd1);
        check("t4b_code", {30'd0, err_code}, 32'd3);
        repeat (9) @(negedge clk);
        send_str("5+");
        send_byte("x");
        check("t4c_err", {31'd0, err}, 32'd1);
        check("t4c_code", {30'd0, err_code}, 32'd1);
        repeat (9) @(negedge clk);
        send_str("\r");
        check("t4_nstart", starts - base_s, 32'd0);
        check("t4_nerr", errs - base_e, 32'd3);
        send_str("a*b");
        send_byte(8'h0D);
        check("t4d_start", {31'd0, alu_start}, 32'd1);
        check("t4d_op_a", op_a, 32'hA);
        check("t4d_op_b", op_b, 32'hB);
        check("t4d_opcode", {30'd0, opcode}, 32'd2);

        // bytes while busy, incl. same cycle as alu_done
        repeat (4) @(negedge clk);
        send_byte("7");
        check("t5a_err", {31'd0, err}, 32'd1);
        check("t5a_code", {30'd0, err_code}, 32'd0);
        check("t5a_op_a", op_a, 32'hA);
        check("t5a_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        uart_in       = "9";
        uart_in_valid = 1'b1;
        alu_done      = 1'b1;
        @(negedge clk);
        uart_in_valid = 1'b0;
        alu_done      = 1'b0;
        check("t5b_err", {31'd0, err}, 32'd1);
        check("t5b_code", {30'd0, err_code}, 32'd0);
        check("t5b_busy", {31'd0, busy}, 32'd0);
        repeat (9) @(negedge clk);
        send_str("4+5");
        send_byte(8'h0D);
        check("t5c_op_a", op_a, 32'h4);
        check("t5c_op_b", op_b, 32'h5);
        done_pulse();

        // async reset mid-operand, then spaced command
        send_str("12");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        send_str("3 & 4");
        send_byte(8'h0D);
        check("t6_start", {31'd0, alu_start}, 32'd1);
        check("t6_op_a", op_a, 32'h3);
        check("t6_op_b", op_b, 32'h4);
        check("t6_opcode", {30'd0, opcode}, 32'd3);
        done_pulse();
        check("t6_busy_clr", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
